decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32 field/immediate decoder with output+skid buffering; `DECODE_ILLEGAL_CHECK_EN enables illegal-instruction flagging
module decode_stage #(
  parameter int PC_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [2:0]       instr_type,
  output logic [31:0]      imm,
  output logic [PC_W-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [4:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [2:0]       instr_type;
    logic [31:0]      imm;
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;
  state_t state, state_nx;
  entry_t dec, out_q, skid_q;
  logic [31:0] i;
  logic [2:0] t;
  logic in_xfer, out_xfer, load_out_in, load_out_skid, load_skid;
  assign i = in_instr;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign {opcode, rd, rs1, rs2, funct3, funct7, instr_type, imm, out_pc, out_tag, illegal} = out_q;
  // opcode to instruction class (R=0 I=1 S=2 B=3 U=4 J=5 NONE=7)
  always_comb begin
    t = 3'd7;
    case (i[6:2])
      5'b01100:                            t = 3'd0;
      5'b00000, 5'b00100, 5'b11001, 5'b11100: t = 3'd1;
      5'b01000:                            t = 3'd2;
      5'b11000:                            t = 3'd3;
      5'b01101, 5'b00101:                  t = 3'd4;
      5'b11011:                            t = 3'd5;
      default:                             t = 3'd7;
    endcase
  end
  // field extraction, immediate assembly and legality of the offered instruction
  always_comb begin
    dec = '0;
    dec.opcode = i[6:2];
    dec.rd = i[11:7];
    dec.funct3 = i[14:12];
    dec.rs1 = i[19:15];
    dec.rs2 = i[24:20];
    dec.funct7 = i[31:25];
    dec.instr_type = t;
    dec.imm = t == 3'd1 ? {{20{i[31]}}, i[31:20]} :
              t == 3'd2 ? {{20{i[31]}}, i[31:25], i[11:7]} :
              t == 3'd3 ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
              t == 3'd4 ? {i[31:12], 12'b0} :
              t == 3'd5 ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
    dec.pc = in_pc;
    dec.tag = in_tag;
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = i[1:0] != 2'b11 || t == 3'd7;
`else
    dec.illegal = 1'b0;
`endif
  end
  // occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  // next occupancy and which register captures what; flush overrides everything
  always_comb begin
    state_nx = state;
    load_out_in = 1'b0;
    load_out_skid = 1'b0;
    load_skid = 1'b0;
    if (flush) state_nx = EMPTY;
    else case (state)
      EMPTY: if (in_xfer) begin
        state_nx = ONE;
        load_out_in = 1'b1;
      end
      ONE: if (in_xfer && out_xfer) load_out_in = 1'b1;
      else if (in_xfer) begin
        state_nx = FULL;
        load_skid = 1'b1;
      end
      else if (out_xfer) state_nx = EMPTY;
      FULL: if (out_xfer) begin
        state_nx = ONE;
        load_out_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // data registers load only on a transfer, so they hold while stalled or empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in) out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid) skid_q <= dec;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random valid/ready checks of decode_stage against a scoreboard
module tb_decode_stage;
  localparam int PC_W = 32;
  localparam int TAG_W = 4;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, illegal;
  logic [31:0] in_instr = 0, imm;
  logic [PC_W-1:0] in_pc = 0, out_pc;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  logic [4:0] opcode, rd, rs1, rs2;
  logic [2:0] funct3, instr_type;
  logic [6:0] funct7;
  int checks = 0, errors = 0, accepted = 0, base = 0;
  logic [127:0] sb[$];
  logic [127:0] snap = 0;
  logic stall_prev = 0;

  decode_stage #(.PC_W(PC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .instr_type(instr_type), .imm(imm), .out_pc(out_pc), .out_tag(out_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [31:0] x, input logic [PC_W-1:0] pc, input logic [TAG_W-1:0] tg);
    logic [2:0] ty;
    logic [31:0] im;
    logic [12:0] b13;
    logic [20:0] j21;
    logic il;
    case (x[6:2])
      5'h0C: ty = 3'd0;
      5'h00, 5'h04, 5'h19, 5'h1C: ty = 3'd1;
      5'h08: ty = 3'd2;
      5'h18: ty = 3'd3;
      5'h0D, 5'h05: ty = 3'd4;
      5'h1B: ty = 3'd5;
      default: ty = 3'd7;
    endcase
    b13 = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    j21 = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    im = 32'($signed(x) >>> 20);
    case (ty)
      3'd1: im = im;
      3'd2: im = {im[31:5], x[11:7]};
      3'd3: im = 32'($signed(b13));
      3'd4: im = {x[31:12], 12'h000};
      3'd5: im = 32'($signed(j21));
      default: im = 32'h0;
    endcase
    il = ILL_EN && (x[1:0] != 2'b11 || ty == 3'd7);
    return 128'({x[6:2], x[11:7], x[19:15], x[24:20], x[14:12], x[31:25], ty, im, pc, tg, il});
  endfunction

  function automatic logic [127:0] obs();
    return 128'({opcode, rd, rs1, rs2, funct3, funct7, instr_type, imm, out_pc, out_tag, illegal});
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic offer(input logic [31:0] x, input logic [PC_W-1:0] pc, input logic [TAG_W-1:0] tg);
    in_valid = 1;
    in_instr = x;
    in_pc = pc;
    in_tag = tg;
  endtask

  task automatic cyc();
    logic [127:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_entry", obs(), e);
      end
    end
    if (stall_prev && out_valid) chk("stall_stable", obs(), snap);
    stall_prev = out_valid && !out_ready;
    snap = obs();
    if (flush) sb.delete();
    else if (in_valid && in_ready) begin
      sb.push_back(model(in_instr, in_pc, in_tag));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_illegal", 128'(illegal), 128'(0));
    chk("rst_imm", 128'(imm), 128'(0));
    #11 rst_n = 1;
    @(posedge clk);
    #1;
    offer(32'hFFF00093, 32'h100, 4'h1);
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("i_valid", 128'(out_valid), 128'(1));
    chk("i_type", 128'(instr_type), 128'(1));
    chk("i_rd", 128'(rd), 128'(1));
    chk("i_imm", 128'(imm), 128'(32'hFFFFFFFF));
    cyc();
    offer(32'hFE000EE3, 32'h104, 4'h2);
    cyc();
    in_valid = 0;
    chk("b_type", 128'(instr_type), 128'(3));
    chk("b_imm", 128'(imm), 128'(32'hFFFFFFFC));
    offer(32'hFE000E63, 32'h108, 4'h3);
    cyc();
    in_valid = 0;
    chk("b_imm_neg2052", 128'(imm), 128'(32'hFFFFF7FC));
    cyc();
    out_ready = 0;
    offer(32'h00000013, 32'h200, 4'h4);
    cyc();
    offer(32'h00100093, 32'h204, 4'h5);
    cyc();
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_hold_a", 128'(out_pc), 128'(32'h200));
    offer(32'h00200113, 32'h208, 4'h6);
    cyc();
    chk("bp_still_full", 128'(in_ready), 128'(0));
    chk("bp_still_a", 128'(out_pc), 128'(32'h200));
    out_ready = 1;
    cyc();
    chk("bp_then_b", 128'(out_pc), 128'(32'h204));
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    cyc();
    in_valid = 0;
    chk("bp_then_c", 128'(out_pc), 128'(32'h208));
    cyc();
    chk("bp_drained", 128'(out_valid), 128'(0));
    out_ready = 0;
    offer(32'h00300193, 32'h300, 4'h7);
    cyc();
    offer(32'h00400213, 32'h304, 4'h8);
    cyc();
    chk("fl_full", 128'(in_ready), 128'(0));
    flush = 1;
    offer(32'h00500293, 32'h308, 4'h9);
    cyc();
    flush = 0;
    in_valid = 0;
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1;
    repeat (3) cyc();
    chk("fl_nothing", 128'(out_valid), 128'(0));
    out_ready = 0;
    offer(32'h00600313, 32'h400, 4'hA);
    cyc();
    flush = 1;
    offer(32'h00700393, 32'h404, 4'hB);
    cyc();
    flush = 0;
    in_valid = 0;
    chk("fl1_out_valid", 128'(out_valid), 128'(0));
    out_ready = 1;
    repeat (2) cyc();
    chk("fl1_nothing", 128'(out_valid), 128'(0));
    offer(32'h00000000, 32'h500, 4'hC);
    cyc();
    in_valid = 0;
    chk("ill_zero", 128'(illegal), 128'(ILL_EN));
    chk("ill_zero_type", 128'(instr_type), 128'(1));
    cyc();
    offer(32'h00000013, 32'h504, 4'hD);
    cyc();
    in_valid = 0;
    chk("ill_nop", 128'(illegal), 128'(0));
    cyc();
    out_ready = 0;
    offer(32'hFFF00093, 32'h600, 4'hE);
    cyc();
    offer(32'h00800413, 32'h604, 4'hF);
    cyc();
    in_valid = 0;
    chk("rs_full", 128'(in_ready), 128'(0));
    rst_n = 0;
    #1;
    chk("rs_out_valid", 128'(out_valid), 128'(0));
    chk("rs_in_ready", 128'(in_ready), 128'(1));
    chk("rs_imm", 128'(imm), 128'(0));
    #1 rst_n = 1;
    sb.delete();
    stall_prev = 0;
    offer(32'h00900493, 32'h700, 4'h1);
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("rs_first_valid", 128'(out_valid), 128'(1));
    chk("rs_first_pc", 128'(out_pc), 128'(32'h700));
    cyc();
    base = accepted;
    for (int c = 0; c < 60000 && accepted - base < 10000; c++) begin
      in_valid = $urandom_range(9) < 7;
      in_instr = $urandom();
      in_pc = $urandom();
      in_tag = 4'($urandom());
      out_ready = $urandom_range(9) < 6;
      cyc();
    end
    chk("soak_count", 128'(accepted - base), 128'(10000));
    in_valid = 0;
    out_ready = 1;
    repeat (4) cyc();
    chk("soak_drain", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
